graph_trace_coder: RTL and testbench
====================================

// Module: graph_trace_coder
// PURPOSE
//  Stores a rolling history of the five sensor traces (HUM, TEMP, MAGX, MAGY, MAGZ).
//  For every VGA pixel it produces the 6-bit px_code consumed by the graph colour mixer:
//   - bit i set: trace i passes through this pixel (i = 0..4).
//   - bit 5 set: pixel lies on the graph axes.
//  Sits between the sensor sample path and the colour mixer, in the VGA pixel-clock domain.
// PARAMETERS
//  GRAPH_W   256  columns (samples kept per trace); power of two
//  GRAPH_H   128  rows; power of two, <= 256
//  X0        64   screen x of graph column 0
//  Y0        48   screen y of graph row 0 (top)
// PORTS
//  clk           in   1      pixel clock
//  rst_n         in   1      synchronous reset, active low
//  clear         in   1      empty the history (1-cycle pulse)
//  freeze        in   1      1 = stop accepting samples (display hold)
//  sample_valid  in   1      sample set offered
//  sample_ready  out  1      sample set accepted when valid & ready
//  sample_data   in   40     {magz,magy,magx,temp,hum}, 8b unsigned each
//  px_valid      in   1      px_x/px_y refer to a visible pixel
//  px_x          in   10     screen column (increments by 1 along a line)
//  px_y          in   10     screen row
//  px_code       out  6      trace/axis code for the pixel (to colour mixer)
//  px_code_valid out  1      px_code corresponds to px_valid two cycles earlier
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - wr_ptr=0, count=0, sample_ready=0, px_code=0, px_code_valid=0, pipeline registers cleared.
//   - Storage contents are don't-care (count=0 masks them).
//   - Reset mid-frame aborts in-flight pixels; no valid output for 2 cycles after release.
//  Sample side:
//   - sample_ready = !freeze && !clear, registered-free; 0 while in reset.
//   - Accept: write 5 bytes at wr_ptr; wr_ptr <= wr_ptr+1 mod GRAPH_W; count <= min(count+1, GRAPH_W).
//   - clear: wr_ptr=0, count=0 next cycle; clear wins over a same-cycle accept (not accepted).
//  Pixel side, 2-cycle pipeline (px_valid -> px_code_valid, fixed latency, no stall):
//   - col = px_x - X0, row = px_y - Y0.
//   - in_graph = px_valid && 0 <= col < GRAPH_W && 0 <= row < GRAPH_H.
//   - Read address: count < GRAPH_W ? col : (wr_ptr + col) mod GRAPH_W, so the oldest sample is leftmost.
//   - col >= count: no sample; trace bits 0.
//   - Stage 1: memory read (read-before-write: a same-cycle write is not seen).
//   - Stage 2: per trace, vrow = GRAPH_H-1 - (value >> (8 - log2 GRAPH_H)).
//       - prev_vrow = that trace's vrow for col-1 on the same line.
//       - prev_vrow = vrow when col==0 or col-1 had no sample.
//       - bit i = 1 iff min(vrow,prev_vrow) <= row <= max(vrow,prev_vrow), giving continuous lines.
//   - bit 5 = in_graph && (col==0 || row==GRAPH_H-1).
//   - !in_graph -> px_code=0; px_code_valid still follows px_valid.
//   - Multiple trace bits may be set simultaneously; the mixer handles the overlap.
//  Widths: col/row computed 11b signed; vrow 8b; all compares unsigned after range check.
// TESTING
//  - Reset, 5 clocks: px_code=0, px_code_valid=0, sample_ready=0; ready=1 the cycle after rst_n=1.
//  - Empty history: px at (X0,Y0+GRAPH_H-1) -> px_code=6'b100000; px at (X0+5,Y0+10) -> 0.
//  - One sample hum=255, others 0; scan line y=Y0 (GRAPH_H=128):
//      - col 0 -> 6'b100001 (axis + hum).
//      - col 1 -> 0.
//      - on line y=Y0+127: col 0 -> 6'b111110 (axis + traces 1-4 at vrow 127).
//  - Step: samples hum=0 then hum=254; line y=Y0+64, col 1 -> bit0=1 (vertical segment 127..0).
//  - Wrap: push 300 samples with hum=k mod 256 -> col 0 shows sample 44, col 255 shows sample 299.
//  - freeze=1 -> sample_ready=0, history unchanged.
//  - clear together with valid -> not accepted, count=0.
//  - rst_n low mid-line -> px_code_valid=0 for 2 cycles after release.

Source files
------------

// File: rtl/graph_trace_coder.sv
// graph_trace_coder
// Keeps a rolling history of five 8-bit sensor traces and, for each VGA pixel,
// produces a 6-bit code: bits 0..4 mark traces crossing the pixel, bit 5 marks
// the graph axes. The pixel path is a fixed two-cycle pipeline with no stall.
module graph_trace_coder #(
   parameter int GRAPH_W = 256,
   parameter int GRAPH_H = 128,
   parameter int X0      = 64,
   parameter int Y0      = 48
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        freeze,
   input  logic        sample_valid,
   output logic        sample_ready,
   input  logic [39:0] sample_data,
   input  logic        px_valid,
   input  logic [9:0]  px_x,
   input  logic [9:0]  px_y,
   output logic [5:0]  px_code,
   output logic        px_code_valid
);
   localparam int COL_W = $clog2(GRAPH_W);
   localparam int ROW_W = $clog2(GRAPH_H);
   localparam int CNT_W = COL_W + 1;
   localparam int SHIFT = 8 - ROW_W;
   localparam int NTR   = 5;

   // ---------------- sample side ----------------
   logic             run_reg;
   logic [COL_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [39:0]      mem [GRAPH_W];
   logic             accept;

   // Ready is a pure function of the controls; run_reg holds it low until the
   // first clock edge after reset is released.
   assign sample_ready = rst_n && run_reg && !freeze && !clear;
   assign accept       = sample_valid && sample_ready;

   // Write pointer and fill level of the circular history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_reg    <= 1'b0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         run_reg <= 1'b1;
         if (clear) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
         end else if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (count_reg != CNT_W'(GRAPH_W))
               count_reg <= count_reg + 1'b1;
         end
      end
   end

   // History storage write port (contents need no reset: count masks them)
   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr_reg] <= sample_data;
   end

   // ---------------- pixel decode (cycle 0) ----------------
   logic signed [10:0] col;
   logic signed [10:0] row;
   logic               col_ok;
   logic               row_ok;
   logic               in_graph;
   logic [COL_W-1:0]   col_idx;
   logic [ROW_W-1:0]   row_idx;
   logic               has_sample;
   logic [COL_W-1:0]   rd_addr;

   assign col      = $signed({1'b0, px_x}) - $signed(11'(X0));
   assign row      = $signed({1'b0, px_y}) - $signed(11'(Y0));
   assign col_ok   = !col[10] && (col[9:0] < 10'(GRAPH_W));
   assign row_ok   = !row[10] && (row[9:0] < 10'(GRAPH_H));
   assign in_graph = px_valid && col_ok && row_ok;
   assign col_idx  = col[COL_W-1:0];
   assign row_idx  = row[ROW_W-1:0];
   // Columns beyond the fill level have no sample yet
   assign has_sample = {1'b0, col_idx} < count_reg;
   // Once the buffer has wrapped, the oldest sample sits at wr_ptr and is drawn leftmost
   assign rd_addr  = (count_reg < CNT_W'(GRAPH_W)) ? col_idx : (wr_ptr_reg + col_idx);

   // ---------------- stage 1 ----------------
   logic             s1_valid;
   logic             s1_in_graph;
   logic             s1_has;
   logic [COL_W-1:0] s1_col;
   logic [ROW_W-1:0] s1_row;
   logic [39:0]      rd_data_reg;

   // Capture pixel geometry alongside the history read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_in_graph <= 1'b0;
         s1_has      <= 1'b0;
         s1_col      <= '0;
         s1_row      <= '0;
      end else begin
         s1_valid    <= px_valid;
         s1_in_graph <= in_graph;
         s1_has      <= in_graph && has_sample;
         s1_col      <= col_idx;
         s1_row      <= row_idx;
      end
   end

   // Registered read port; a same-cycle write is not visible (read-before-write)
   always_ff @(posedge clk) begin
      rd_data_reg <= mem[rd_addr];
   end

   // ---------------- stage 2 ----------------
   logic [NTR-1:0][7:0] vrow;
   logic [NTR-1:0][7:0] prev_vrow_reg;
   logic                prev_ok_reg;
   logic [COL_W-1:0]    prev_col_reg;
   logic [ROW_W-1:0]    prev_row_reg;
   logic                link;
   logic [NTR-1:0]      hit;
   logic [7:0]          row8;
   logic                axis;
   logic [5:0]          code_next;

   // Join to the previous pixel only if it was column col-1 of this same line
   // and carried a sample; otherwise the trace is drawn as a single point.
   assign link = prev_ok_reg && (s1_col != '0) &&
                 (prev_col_reg + 1'b1 == s1_col) && (prev_row_reg == s1_row);
   assign row8 = 8'(s1_row);

   genvar gi;
   generate
      for (gi = 0; gi < NTR; gi++) begin : g_trace
         logic [7:0] val;
         logic [7:0] pv;
         logic [7:0] lo;
         logic [7:0] hi;
         assign val      = rd_data_reg[gi*8 +: 8];
         assign vrow[gi] = 8'(GRAPH_H-1) - (val >> SHIFT);
         assign pv       = link ? prev_vrow_reg[gi] : vrow[gi];
         assign lo       = (pv < vrow[gi]) ? pv : vrow[gi];
         assign hi       = (pv < vrow[gi]) ? vrow[gi] : pv;
         assign hit[gi]  = s1_has && (row8 >= lo) && (row8 <= hi);
      end
   endgenerate

   assign axis      = s1_in_graph && ((s1_col == '0) || (s1_row == ROW_W'(GRAPH_H-1)));
   assign code_next = s1_in_graph ? {axis, hit} : 6'd0;

   // Output register plus the previous-column memory used for line joining
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         px_code       <= 6'd0;
         px_code_valid <= 1'b0;
         prev_ok_reg   <= 1'b0;
         prev_col_reg  <= '0;
         prev_row_reg  <= '0;
         prev_vrow_reg <= '0;
      end else begin
         px_code_valid <= s1_valid;
         px_code       <= code_next;
         if (s1_valid) begin
            prev_ok_reg   <= s1_in_graph && s1_has;
            prev_col_reg  <= s1_col;
            prev_row_reg  <= s1_row;
            prev_vrow_reg <= vrow;
         end
      end
   end
endmodule

// File: tb/tb_graph_trace_coder.sv
// Testbench for graph_trace_coder: drives sample and pixel streams and compares
// against a queue-based model of the visible history.
module tb_graph_trace_coder;
   localparam int GW = 256;
   localparam int GH = 128;
   localparam int X0 = 64;
   localparam int Y0 = 48;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        freeze = 1'b0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [39:0] sample_data = '0;
   logic        px_valid = 1'b0;
   logic [9:0]  px_x = '0;
   logic [9:0]  px_y = '0;
   logic [5:0]  px_code;
   logic        px_code_valid;

   int n_checks = 0;
   int n_fail   = 0;

   graph_trace_coder #(.GRAPH_W(GW), .GRAPH_H(GH), .X0(X0), .Y0(Y0)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .freeze(freeze),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
      .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
      .px_code(px_code), .px_code_valid(px_code_valid)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [39:0] hist[$];      // accepted samples, oldest first, at most GW kept
   bit          run_m = 1'b0; // an edge with rst_n high has occurred

   function automatic int vrow_of(int v);
      return (GH - 1) - (v / (256 / GH));
   endfunction

   function automatic logic [5:0] model_code(int x, int y);
      int col, row, n, base, cur, prv, lo, hi;
      logic [39:0] w, wp;
      logic [5:0]  c;
      col = x - X0;
      row = y - Y0;
      c = '0;
      if (col < 0 || col >= GW || row < 0 || row >= GH) return c;
      c[5] = (col == 0) || (row == GH - 1);
      n = (hist.size() < GW) ? hist.size() : GW;
      base = hist.size() - n;
      if (col < n) begin
         w  = hist[base + col];
         wp = (col > 0) ? hist[base + col - 1] : w;
         for (int t = 0; t < 5; t++) begin
            cur = vrow_of(int'(w[8*t +: 8]));
            prv = vrow_of(int'(wp[8*t +: 8]));
            lo  = (cur < prv) ? cur : prv;
            hi  = (cur < prv) ? prv : cur;
            c[t] = (row >= lo) && (row <= hi);
         end
      end
      return c;
   endfunction

   // ---------------- one clock of stimulus ----------------
   bit          pend_v = 1'b0;
   logic [5:0]  pend_code = '0;
   int          pend_x = 0, pend_y = 0;
   bit          exp_v, exp_ready;
   logic [5:0]  exp_code;
   logic        obs_v, obs_ready;
   logic [5:0]  obs_code;
   int          chk_x, chk_y;

   // Applies the currently driven inputs for one clock and leaves, in exp_*/obs_*,
   // the expected and observed outputs for the pixel offered one tick earlier.
   task automatic tick();
      bit         acc, rst_edge;
      logic [5:0] cur_code;
      #1;
      cur_code  = px_valid ? model_code(int'(px_x), int'(px_y)) : 6'd0;
      exp_ready = rst_n && run_m && !freeze && !clear;
      obs_ready = sample_ready;
      acc       = sample_valid && exp_ready;
      rst_edge  = !rst_n;
      @(posedge clk);
      #1;
      if (rst_edge) begin
         hist.delete();
         run_m = 1'b0;
         exp_v = 1'b0; exp_code = 6'd0; chk_x = -1; chk_y = -1;
         pend_v = 1'b0;
      end else begin
         run_m = 1'b1;
         if (clear) hist.delete();
         else if (acc) begin
            hist.push_back(sample_data);
            if (hist.size() > GW) void'(hist.pop_front());
         end
         exp_v = pend_v; exp_code = pend_code; chk_x = pend_x; chk_y = pend_y;
         pend_v = px_valid; pend_code = cur_code; pend_x = int'(px_x); pend_y = int'(px_y);
      end
      obs_v    = px_code_valid;
      obs_code = px_code;
   endtask

   task automatic px_step(bit v, int x, int y);
      px_valid = v; px_x = 10'(x); px_y = 10'(y);
      tick();
   endtask

   task automatic push(logic [39:0] d);
      sample_valid = 1'b1; sample_data = d;
      tick();
      sample_valid = 1'b0;
   endtask

   function automatic logic [39:0] rnd40();
      return {8'($urandom), 32'($urandom)};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; px_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         px_x = 10'(X0 + i); px_y = 10'(Y0);
         tick();
         n_checks++;
         if (obs_code !== 6'd0 || obs_v !== 1'b0 || obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset cyc%0d: code=%b valid=%b ready=%b, want 000000/0/0", i, obs_code, obs_v, obs_ready);
         end
      end
      px_valid = 1'b0; rst_n = 1'b1;
      tick();
      tick();
      n_checks++;
      if (obs_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: ready=%b want 1", obs_ready);
      end
   endtask

   task automatic test_empty();
      int ys[2] = '{Y0 + GH - 1, Y0 + 10};
      foreach (ys[k]) begin
         for (int x = X0 - 2; x <= X0 + GW + 3; x++) begin
            px_step(x <= X0 + GW + 1, x, ys[k]);
            n_checks++;
            if (obs_v !== exp_v || (exp_v && obs_code !== exp_code)) begin
               n_fail++;
               $display("FAIL empty_scan (%0d,%0d): v=%b code=%b want v=%b code=%b", chk_x, chk_y, obs_v, obs_code, exp_v, exp_code);
            end
            if (exp_v && chk_x == X0 && chk_y == Y0 + GH - 1) begin
               n_checks++;
               if (obs_code !== 6'b100000) begin
                  n_fail++; $display("FAIL empty_axis_corner: code=%b want 100000", obs_code);
               end
            end
            if (exp_v && chk_x == X0 + 5 && chk_y == Y0 + 10) begin
               n_checks++;
               if (obs_code !== 6'b000000) begin
                  n_fail++; $display("FAIL empty_inside: code=%b want 000000", obs_code);
               end
            end
         end
      end
   endtask

   task automatic test_single();
      int ys[2] = '{Y0, Y0 + GH - 1};
      clear = 1'b1; tick(); clear = 1'b0;
      push({8'd0, 8'd0, 8'd0, 8'd0, 8'd255});
      foreach (ys[k]) begin
         for (int x = X0 - 2; x <= X0 + GW + 3; x++) begin
            px_step(x <= X0 + GW + 1, x, ys[k]);
            n_checks++;
            if (obs_v !== exp_v || (exp_v && obs_code !== exp_code)) begin
               n_fail++;
               $display("FAIL single_scan (%0d,%0d): v=%b code=%b want v=%b code=%b", chk_x, chk_y, obs_v, obs_code, exp_v, exp_code);
            end
            if (exp_v && chk_y == Y0 && (chk_x == X0 || chk_x == X0 + 1)) begin
               n_checks++;
               if (obs_code !== ((chk_x == X0) ? 6'b100001 : 6'b000000)) begin
                  n_fail++; $display("FAIL single_top col%0d: code=%b", chk_x - X0, obs_code);
               end
            end
            if (exp_v && chk_y == Y0 + GH - 1 && chk_x == X0) begin
               n_checks++;
               if (obs_code !== 6'b111110) begin
                  n_fail++; $display("FAIL single_bottom col0: code=%b want 111110", obs_code);
               end
            end
         end
      end
   endtask

   task automatic test_step();
      clear = 1'b1; tick(); clear = 1'b0;
      push({rnd40() & 40'hFFFF_FFFF_00});
      push({rnd40() & 40'hFFFF_FFFF_00} | 40'd254);
      for (int x = X0 - 2; x <= X0 + GW + 3; x++) begin
         px_step(x <= X0 + GW + 1, x, Y0 + 64);
         n_checks++;
         if (obs_v !== exp_v || (exp_v && obs_code !== exp_code)) begin
            n_fail++;
            $display("FAIL step_scan (%0d,%0d): v=%b code=%b want v=%b code=%b", chk_x, chk_y, obs_v, obs_code, exp_v, exp_code);
         end
         if (exp_v && chk_x == X0 + 1) begin
            n_checks++;
            if (obs_code[0] !== 1'b1) begin
               n_fail++; $display("FAIL step_segment col1: bit0=%b want 1", obs_code[0]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      int ys[2] = '{Y0 + 105, Y0 + 106};
      clear = 1'b1; tick(); clear = 1'b0;
      for (int k = 0; k < 300; k++) begin
         push((rnd40() & ~40'hFF) | 40'(k % 256));
         n_checks++;
         if (obs_ready !== 1'b1) begin
            n_fail++; $display("FAIL wrap_ready k=%0d: ready=%b want 1", k, obs_ready);
         end
      end
      foreach (ys[j]) begin
         for (int x = X0 - 2; x <= X0 + GW + 3; x++) begin
            px_step(x <= X0 + GW + 1, x, ys[j]);
            n_checks++;
            if (obs_v !== exp_v || (exp_v && obs_code !== exp_code)) begin
               n_fail++;
               $display("FAIL wrap_scan (%0d,%0d): v=%b code=%b want v=%b code=%b", chk_x, chk_y, obs_v, obs_code, exp_v, exp_code);
            end
            if (exp_v && chk_y == Y0 + 105 && chk_x == X0) begin
               n_checks++;
               if (obs_code[0] !== 1'b1) begin
                  n_fail++; $display("FAIL wrap_oldest col0 row105: bit0=%b want 1", obs_code[0]);
               end
            end
            if (exp_v && chk_x == X0 + GW - 1) begin
               n_checks++;
               if (obs_code[0] !== (chk_y == Y0 + 106)) begin
                  n_fail++; $display("FAIL wrap_newest col255 row%0d: bit0=%b", chk_y - Y0, obs_code[0]);
               end
            end
         end
      end
   endtask

   task automatic test_freeze();
      int y;
      freeze = 1'b1;
      for (int k = 0; k < 10; k++) begin
         push(rnd40());
         n_checks++;
         if (obs_ready !== 1'b0) begin
            n_fail++; $display("FAIL freeze_ready k=%0d: ready=%b want 0", k, obs_ready);
         end
      end
      freeze = 1'b0;
      y = $urandom_range(Y0, Y0 + GH - 1);
      for (int x = X0 - 2; x <= X0 + GW + 3; x++) begin
         px_step(x <= X0 + GW + 1, x, y);
         n_checks++;
         if (obs_v !== exp_v || (exp_v && obs_code !== exp_code)) begin
            n_fail++;
            $display("FAIL freeze_scan (%0d,%0d): v=%b code=%b want v=%b code=%b", chk_x, chk_y, obs_v, obs_code, exp_v, exp_code);
         end
      end
   endtask

   task automatic test_clear_valid();
      clear = 1'b1;
      push(rnd40());
      clear = 1'b0;
      n_checks++;
      if (obs_ready !== 1'b0) begin
         n_fail++; $display("FAIL clear_ready: ready=%b want 0", obs_ready);
      end
      for (int x = X0 - 2; x <= X0 + GW + 3; x++) begin
         px_step(x <= X0 + GW + 1, x, Y0 + GH - 1);
         n_checks++;
         if (obs_v !== exp_v || (exp_v && obs_code !== exp_code)) begin
            n_fail++;
            $display("FAIL clear_scan (%0d,%0d): v=%b code=%b want v=%b code=%b", chk_x, chk_y, obs_v, obs_code, exp_v, exp_code);
         end
         if (exp_v && chk_x == X0 + 1) begin
            n_checks++;
            if (obs_code !== 6'b100000) begin
               n_fail++; $display("FAIL clear_empty col1: code=%b want 100000", obs_code);
            end
         end
      end
   endtask

   task automatic test_random();
      int n, y;
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            clear = 1'b1; tick(); clear = 1'b0;
         end
         n = $urandom_range(0, 120);
         for (int k = 0; k < n; k++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            freeze = ($urandom_range(0, 7) == 0);
            sample_data = rnd40();
            tick();
            n_checks++;
            if (obs_ready !== exp_ready) begin
               n_fail++; $display("FAIL random_ready it%0d k%0d: ready=%b want %b", it, k, obs_ready, exp_ready);
            end
         end
         sample_valid = 1'b0; freeze = 1'b0;
         y = $urandom_range(Y0 - 2, Y0 + GH + 1);
         for (int x = X0 - 2; x <= X0 + GW + 3; x++) begin
            px_step(x <= X0 + GW + 1, x, y);
            n_checks++;
            if (obs_v !== exp_v || (exp_v && obs_code !== exp_code)) begin
               n_fail++;
               $display("FAIL random_scan (%0d,%0d): v=%b code=%b want v=%b code=%b", chk_x, chk_y, obs_v, obs_code, exp_v, exp_code);
            end
         end
      end
   endtask

   task automatic test_reset_midline();
      for (int k = 0; k < 20; k++) push(rnd40());
      for (int x = X0 - 2; x <= X0 + GW + 3; x++) begin
         if (x == X0 + 50) rst_n = 1'b0;
         if (x == X0 + 53) rst_n = 1'b1;
         px_step(x <= X0 + GW + 1, x, Y0 + 20);
         n_checks++;
         if (obs_v !== exp_v || (exp_v && obs_code !== exp_code)) begin
            n_fail++;
            $display("FAIL midreset_scan (%0d,%0d): v=%b code=%b want v=%b code=%b", chk_x, chk_y, obs_v, obs_code, exp_v, exp_code);
         end
         if (x == X0 + 53) begin
            n_checks++;
            if (obs_v !== 1'b0) begin
               n_fail++; $display("FAIL midreset_release: valid=%b want 0", obs_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_single();
      test_step();
      test_wrap();
      test_freeze();
      test_clear_valid();
      test_random();
      test_reset_midline();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
